// File: rtl/alu_cmd_ctrl.sv
// Command-side ALU controller: parses RX bytes into A/B/function commands, pulses ALU_EN
// once per command and returns the 2*DATA_WIDTH-bit result over TX as two bytes, LSB first.
module alu_cmd_ctrl #(
    parameter int DATA_WIDTH     = 8,
    parameter int SELECTION_LINE = 4,
    parameter int TIMEOUT        = 8
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [DATA_WIDTH-1:0]     RX_P_DATA,
    input  logic                      RX_D_VLD,
    output logic [DATA_WIDTH-1:0]     A,
    output logic [DATA_WIDTH-1:0]     B,
    output logic [SELECTION_LINE-1:0] ALU_FUN,
    output logic                      ALU_EN,
    input  logic [2*DATA_WIDTH-1:0]   ALU_OUT,
    input  logic                      OUT_Valid,
    output logic [DATA_WIDTH-1:0]     TX_P_DATA,
    output logic                      TX_D_VLD,
    input  logic                      TX_RDY,
    output logic                      CMD_ERR
);

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [DATA_WIDTH-1:0] CMD_FULL  = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] CMD_REUSE = DATA_WIDTH'(8'hDD);
    localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        GET_A,
        GET_B,
        GET_FUN,
        ALU_REQ,
        ALU_WAIT,
        TX_LO,
        TX_HI
    } state_t;

    state_t                    state_q, state_d;
    logic [DATA_WIDTH-1:0]     a_q, a_d;
    logic [DATA_WIDTH-1:0]     b_q, b_d;
    logic [SELECTION_LINE-1:0] fun_q, fun_d;
    logic [2*DATA_WIDTH-1:0]   result_q, result_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      err_q, err_d;
    logic                      funBad;

    // A function byte with any bit above the select field is rejected outright.
    assign funBad = (RX_P_DATA >> SELECTION_LINE) != '0;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            fun_q    <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            fun_q    <= fun_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        fun_d     = fun_q;
        result_d  = result_q;
        cnt_d     = cnt_q;
        err_d     = 1'b0;
        ALU_EN    = 1'b0;
        TX_D_VLD  = 1'b0;
        TX_P_DATA = '0;

        case (state_q)
            IDLE: begin
                if (RX_D_VLD) begin
                    if (RX_P_DATA == CMD_FULL) begin
                        state_d = GET_A;
                    end else if (RX_P_DATA == CMD_REUSE) begin
                        state_d = GET_FUN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            GET_A: begin
                if (RX_D_VLD) begin
                    a_d     = RX_P_DATA;
                    state_d = GET_B;
                end
            end
            GET_B: begin
                if (RX_D_VLD) begin
                    b_d     = RX_P_DATA;
                    state_d = GET_FUN;
                end
            end
            GET_FUN: begin
                if (RX_D_VLD) begin
                    if (funBad) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        fun_d   = RX_P_DATA[SELECTION_LINE-1:0];
                        state_d = ALU_REQ;
                    end
                end
            end
            ALU_REQ: begin
                ALU_EN  = 1'b1;
                err_d   = RX_D_VLD;
                cnt_d   = '0;
                state_d = ALU_WAIT;
            end
            // Bytes arriving while busy are dropped and flagged without disturbing the command.
            ALU_WAIT: begin
                err_d = RX_D_VLD;
                if (OUT_Valid) begin
                    result_d = ALU_OUT;
                    state_d  = TX_LO;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            TX_LO: begin
                TX_D_VLD  = 1'b1;
                TX_P_DATA = result_q[DATA_WIDTH-1:0];
                err_d     = RX_D_VLD;
                if (TX_RDY) begin
                    state_d = TX_HI;
                end
            end
            TX_HI: begin
                TX_D_VLD  = 1'b1;
                TX_P_DATA = result_q[2*DATA_WIDTH-1:DATA_WIDTH];
                err_d     = RX_D_VLD;
                if (TX_RDY) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign A       = a_q;
    assign B       = b_q;
    assign ALU_FUN = fun_q;
    assign CMD_ERR = err_q;

endmodule
